// File: rtl/mux8_ser_pkg.sv
// rtl/mux8_ser_pkg.sv - shared types and constants for mux8_serializer (PARITY encoding exists only with MUX8_SER_PARITY_EN)
package mux8_ser_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;
    localparam logic [SEL_W-1:0] LAST_IDX = 3'd7;

`ifdef MUX8_SER_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;
`else
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;
`endif

endpackage

// File: rtl/mux8to1_sel.sv
// rtl/mux8to1_sel.sv - 8-to-1 single-bit multiplexer
module mux8to1_sel
    import mux8_ser_pkg::*;
(
    input  logic [DATA_W-1:0] I,
    input  logic [SEL_W-1:0]  s,
    output logic              Y
);

    assign Y = I[s];

endmodule

// File: rtl/mux8_serializer.sv
// rtl/mux8_serializer.sv - 8-bit parallel-to-serial converter with framing strobes; MUX8_SER_PARITY_EN adds an even-parity ninth bit
module mux8_serializer
    import mux8_ser_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [SEL_W-1:0]  sel,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              frame_start,
    output logic              frame_done,
    output logic              busy
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  hold_q, hold_d;
    logic [SEL_W-1:0]   shift_sel;
    logic               accept;
    logic               last_bit;
    logic               mux_y;

    assign accept    = in_valid && in_ready;
    assign last_bit  = (cnt_q == LAST_IDX);
    assign shift_sel = MSB_FIRST ? ~cnt_q : cnt_q;

    // Select is forced to 0 outside SHIFT so the mux output is never exposed while idle.
    assign sel = (state_q == SHIFT) ? shift_sel : '0;

    mux8to1_sel u_mux (
        .I (hold_q),
        .s (sel),
        .Y (mux_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    hold_d  = in_data;
                end
            end
            SHIFT: begin
                if (!last_bit) begin
                    cnt_d = cnt_q + 1'b1;
`ifdef MUX8_SER_PARITY_EN
                end else begin
                    state_d = PARITY;
                end
`else
                end else if (accept) begin
                    // Reload on the last bit keeps the serial stream gap-free.
                    cnt_d  = '0;
                    hold_d = in_data;
                end else begin
                    state_d = IDLE;
                end
`endif
            end
`ifdef MUX8_SER_PARITY_EN
            PARITY: begin
                if (accept) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    hold_d  = in_data;
                end else begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready    = 1'b0;
        ser_out     = 1'b0;
        ser_valid   = 1'b0;
        frame_start = 1'b0;
        frame_done  = 1'b0;
        busy        = 1'b0;
        case (state_q)
            IDLE: in_ready = 1'b1;
            SHIFT: begin
                ser_out     = mux_y;
                ser_valid   = 1'b1;
                busy        = 1'b1;
                frame_start = (cnt_q == '0);
`ifndef MUX8_SER_PARITY_EN
                frame_done  = last_bit;
                in_ready    = last_bit;
`endif
            end
`ifdef MUX8_SER_PARITY_EN
            PARITY: begin
                ser_out    = ^hold_q;
                ser_valid  = 1'b1;
                busy       = 1'b1;
                frame_done = 1'b1;
                in_ready   = 1'b1;
            end
`endif
            default: in_ready = 1'b0;
        endcase
    end

endmodule

// File: doc/mux8_serializer.md
# mux8_serializer

Parallel-to-serial converter that accepts an 8-bit word over a valid/ready handshake and shifts it out one bit per clock. A 3-bit bit counter drives the select lines of an internal 8-to-1 multiplexer, which picks the current bit from a held copy of the word. It sits directly upstream of the 8-to-1 mux datapath and owns the select sequencing that the mux itself lacks. Downstream logic sees a serial bit plus framing strobes.

## Interface
- `MSB_FIRST`, default 0: 0 sends bit 0 first (`sel` counts 0..7); 1 sends bit 7 first (`sel` counts 7..0).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: `in_data` is offered.
- `in_ready` output 1: block can accept a word this cycle.
- `in_data` input 8: parallel word; captured when `in_valid && in_ready`.
- `sel` output 3: current mux select, equal to the bit index being sent.
- `ser_out` output 1: serial data bit.
- `ser_valid` output 1: `ser_out` carries a frame bit this cycle.
- `frame_start` output 1: one-cycle pulse on the first bit of a frame.
- `frame_done` output 1: one-cycle pulse on the last bit of a frame.
- `busy` output 1: a frame is in progress.

## Operation
- The state machine has three states: IDLE, SHIFT and PARITY. PARITY exists only when the parity feature is compiled in.
- **IDLE**
  - `in_ready`=1.
  - On accept, the word is latched into `hold_q`, `cnt`=0 and the state moves to SHIFT.
- **SHIFT**
  - Selection: `sel` = `cnt` when `MSB_FIRST`=0, or `~cnt` when `MSB_FIRST`=1.
  - Output: `ser_out` = `hold_q[sel]`, taken from the mux sub-module (combinational from registers). `ser_valid`=1 and `busy`=1.
  - Counting: `cnt` increments every cycle.
  - Strobes: `frame_start` is high when `cnt`=0. `frame_done` is high when `cnt`=7 and parity is disabled.
- **End of SHIFT**, reached at `cnt`=7:
  - Parity disabled: `in_ready`=1 in this cycle. An accept reloads `hold_q`, clears `cnt` and stays in SHIFT, giving zero-gap streaming. With no accept, the state returns to IDLE.
  - Parity enabled: the state moves to PARITY, and `in_ready`=0 at `cnt`=7.
- **Outside SHIFT and PARITY:** `ser_out`=0, `sel`=0 and `ser_valid`=0. The line idles low.
- **Input while busy:** `in_valid` is ignored whenever `in_ready`=0. `in_data` is sampled only on the accept edge, and later changes do not affect the frame in progress.
- **Reset:** asserting `rst_n` low at any time aborts the frame. There is no partial-frame completion after reset.
- **Counter width:** `cnt` is 3 bits and wraps 7 to 0 only on the reload path.

## Timing
- Reset values of every output: `in_ready`=1, `sel`=0, `ser_out`=0, `ser_valid`=0, `frame_start`=0, `frame_done`=0, `busy`=0. Internal state resets to IDLE, `cnt`=0, `hold_q`=0.
- Latency: a word accepted at edge k has its first bit valid in the cycle after edge k. A frame occupies 8 consecutive cycles, or 9 with parity.
- Throughput: one word per 8 cycles (parity off) or one word per 9 cycles (parity on), provided `in_valid` is held continuously.
- `frame_start` and `frame_done` are never both high in the same cycle.

## Configuration
- Macro: `MUX8_SER_PARITY_EN`.
- **Defined:**
  - A ninth cycle in state PARITY sends `ser_out` = ^`hold_q` (even parity), with `ser_valid`=1, `sel`=0 and `frame_done`=1.
  - `in_ready`=1 in the PARITY cycle. An accept in that cycle goes directly to SHIFT with `cnt`=0. Otherwise the state returns to IDLE.
- **Undefined:** the PARITY state, its logic and its encoding are absent, and frames are 8 cycles long.

## Structure
- Shared package `mux8_ser_pkg` holds:
  - the state enum (IDLE, SHIFT, PARITY);
  - `DATA_W`=8;
  - `SEL_W`=3;
  - `LAST_IDX`=3'd7.
- Sub-module `mux8to1_sel`: an 8-to-1 bit multiplexer with inputs `I[7:0]` and `s[2:0]` and output `Y`, fed by `hold_q` and `sel`.

## Test plan
- **Reset values:** hold `rst_n`=0 for 3 cycles, then release. All outputs must match the reset values in Timing, and `in_ready`=1 in the first cycle after release.
- **Single word, LSB first:** accept 0xA5 with `MSB_FIRST`=0.
  - `ser_out` = 1,0,1,0,0,1,0,1 over the next 8 cycles, with `sel` = 0..7.
  - `frame_start` is high in cycle 1 and `frame_done` in cycle 8; IDLE follows.
- **MSB first:** accept 0x80 with `MSB_FIRST`=1. `ser_out` = 1 followed by seven 0s, with `sel` = 7..0.
- **Back-to-back:** offer 0x01 then 0x80 with `in_valid` held high. There are 16 consecutive `ser_valid` cycles with no gap, and `frame_start` pulses at cycles 1 and 9.
- **Abort:** pull `rst_n` low during bit 3 of 0xFF.
  - All outputs are 0 or reset values immediately, with no clock edge required.
  - After release, a word of 0x0F shifts out cleanly as 1,1,1,1,0,0,0,0.
- **Parity (macro defined):** accept 0x07.
  - Bits 1,1,1,0,0,0,0,0 are followed by parity bit 1, with `frame_done` on cycle 9.
  - 0x03 gives parity bit 0.
